// File: rtl/board_ctrl_pkg.sv
// Shared types and constants for the board control block (reset sequencer + input conditioning).
package board_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } rst_state_e;

  localparam int unsigned DB_MIN_CYCLES   = 2;
  localparam int unsigned SYNC_MIN_STAGES = 2;
  localparam int unsigned SYNC_MAX_STAGES = 4;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_debounce.sv
// One-channel synchroniser + debouncer with a registered rise pulse on the debounced level.
module board_debounce
  import board_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < DB_MIN_CYCLES) begin : g_bad_db
    $error("board_debounce: DEBOUNCE_CYCLES below minimum");
  end
  if (SYNC_STAGES < SYNC_MIN_STAGES || SYNC_STAGES > SYNC_MAX_STAGES) begin : g_bad_sync
    $error("board_debounce: SYNC_STAGES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_s;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign d_s = sync_q[SYNC_STAGES-1];

  // Counter runs only while the synced input disagrees with the stable level.
  always_comb begin
    stable_d = stable_q;
    rise_d   = 1'b0;
    cnt_d    = '0;
    if (d_s != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = d_s;
        rise_d   = d_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], d_i};
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q_o    = stable_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/board_ctrl.sv
// Board-level reset sequencer and button/switch conditioning in front of the SoC top.
// Define BOARD_CTRL_SW_DEBOUNCE_EN to debounce switches as well; otherwise they are only synchronised.
module board_ctrl
  import board_ctrl_pkg::*;
#(
  parameter int unsigned NBTN            = 1,
  parameter int unsigned NSW             = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RST_HOLD_CYCLES = 1024
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            pll_locked_i,
  input  logic            sw_rst_i,
  input  logic [NBTN-1:0] btn_i,
  input  logic [NSW-1:0]  sw_i,
  output logic            sys_rst_o,
  output logic [NBTN-1:0] btn_o,
  output logic [NBTN-1:0] btn_rise_o,
  output logic [NSW-1:0]  sw_o
);

  localparam int unsigned HOLD_W = cnt_width(RST_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD_CYCLES - 1);

  if (SYNC_STAGES < SYNC_MIN_STAGES || SYNC_STAGES > SYNC_MAX_STAGES) begin : g_bad_sync
    $error("board_ctrl: SYNC_STAGES out of range");
  end
  if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("board_ctrl: RST_HOLD_CYCLES below minimum");
  end

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  rst_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      cnt_q, cnt_d;
  logic                   sys_rst_q, sys_rst_d;

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      lock_sync_q <= '0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      sys_rst_q   <= 1'b1;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_rst_q   <= sys_rst_d;
    end
  end

  // Loss of lock overrides a soft reset; a soft reset restarts the full hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_MAX) state_d = RUN;
        else                   cnt_d   = cnt_q + HOLD_W'(1);
      end
      RUN: ;
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    if (sw_rst_i && state_q != WAIT_LOCK) begin
      state_d = HOLD;
      cnt_d   = '0;
    end
    if (!lock_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end
    sys_rst_d = (state_d != RUN);
  end

  assign sys_rst_o = sys_rst_q;

  logic [NBTN-1:0] btn_rise;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    board_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clk_i),
      .arstn_i(arstn_i),
      .d_i    (btn_i[i]),
      .q_o    (btn_o[i]),
      .rise_o (btn_rise[i])
    );
  end

  // Both terms are flops; rise pulses are suppressed while the SoC is held in reset.
  assign btn_rise_o = btn_rise & {NBTN{~sys_rst_q}};

`ifdef BOARD_CTRL_SW_DEBOUNCE_EN
  logic [NSW-1:0] sw_rise_unused;

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    board_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clk_i),
      .arstn_i(arstn_i),
      .d_i    (sw_i[i]),
      .q_o    (sw_o[i]),
      .rise_o (sw_rise_unused[i])
    );
  end
`else
  logic [SYNC_STAGES-1:0][NSW-1:0] sw_sync_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) sw_sync_q <= '0;
    else          sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], sw_i};
  end

  assign sw_o = sw_sync_q[SYNC_STAGES-1];
`endif

endmodule
